// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared widths, reset-time configuration and config record for the sequence detector
package seq_det_pkg;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int LEN_W = $clog2(DEF_PAT_W + 1);
  localparam logic [DEF_PAT_W-1:0] RST_PATTERN = 8'b0000_1001;
  localparam int RST_LEN = 4;
  localparam bit RST_OVERLAP = 1'b1;
  typedef struct packed {
    logic [DEF_PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic overlap;
  } seq_det_cfg_t;
endpackage

// File: rtl/seq_det_window.sv
// seq_det_window: shift window, saturating fill counter and length-masked pattern compare
module seq_det_window #(
  parameter int PAT_W = 8,
  parameter int LW = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             overlap,
  output logic             match_now
);
  localparam logic [LW-1:0] FULL = LW'(PAT_W);
  logic [PAT_W-1:0] window, window_next, mask;
  logic [LW-1:0] fill, fill_next;
  always_comb begin
    window_next = {window[PAT_W-2:0], bit_in};
    fill_next = (fill == FULL) ? FULL : fill + 1'b1;
    mask = ~({PAT_W{1'b1}} << len);
    match_now = shift && !clear && len != '0 && fill_next >= len &&
                ((window_next ^ pattern) & mask) == '0;
  end
  // non-overlap only needs fill cleared: the stale window bits are ignored until refilled
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      window <= '0;
      fill <= '0;
    end else if (shift) begin
      window <= window_next;
      fill <= (match_now && !overlap) ? '0 : fill_next;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector; SEQ_DET_MATCH_COUNT_EN builds the match counter
module seq_detector_param import seq_det_pkg::*; #(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(RST_PATTERN),
  parameter int DEF_LEN = RST_LEN,
  parameter bit DEF_OVERLAP = RST_OVERLAP,
  localparam int LW = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_overlap,
  input  logic             count_clr,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count,
  output logic [LW-1:0]    cur_len
);
  localparam logic [LW-1:0] MAX_LEN = LW'(PAT_W);
  logic [PAT_W-1:0] pattern;
  logic [LW-1:0] len;
  logic overlap, match_now;
  seq_det_window #(.PAT_W(PAT_W), .LW(LW)) u_window (
    .clock(clock),
    .reset(reset),
    .clear(cfg_load),
    .shift(in_valid),
    .bit_in(sequence_in),
    .pattern(pattern),
    .len(len),
    .overlap(overlap),
    .match_now(match_now)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern <= DEF_PATTERN;
      len <= LW'(DEF_LEN);
      overlap <= DEF_OVERLAP;
      detector_out <= 1'b0;
    end else begin
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
        overlap <= cfg_overlap;
      end
      detector_out <= match_now;
    end
  end
  assign cur_len = len;
`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count;
  always_ff @(posedge clock) begin
    if (reset || count_clr) count <= '0;
    else if (match_now && !(&count)) count <= count + 1'b1;
  end
  assign match_count = count;
`else
  logic unused_count_clr;
  assign unused_count_clr = count_clr;
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed and random stimulus against a bit-history reference model
module tb_seq_detector_param;
  logic clock = 1'b0;
  logic reset, sequence_in, in_valid, cfg_load, cfg_overlap, count_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic det_a, det_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] len_a, len_b;
  int n_cmp = 0, n_err = 0;
  int hist[$];
  logic [7:0] m_pat;
  int m_len, m_ca, m_cb;
  bit m_ovl, exp_det;

  seq_detector_param dut_a (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detector_out(det_a), .match_count(cnt_a), .cur_len(len_a)
  );
  seq_detector_param #(.CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .detector_out(det_b), .match_count(cnt_b), .cur_len(len_b)
  );

  always #5 clock = ~clock;

  function automatic int ce(int c);
`ifdef SEQ_DET_MATCH_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(bit b, bit v, bit ld, bit clr, bit rst, logic [7:0] p, int l, bit o);
    bit hit;
    sequence_in = b; in_valid = v; cfg_load = ld; count_clr = clr; reset = rst;
    cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = o;
    exp_det = 0;
    if (rst) begin
      hist.delete(); m_pat = 8'b0000_1001; m_len = 4; m_ovl = 1; m_ca = 0; m_cb = 0;
    end else begin
      hit = 0;
      if (ld) begin
        hist.delete(); m_pat = p; m_len = (l > 8) ? 8 : l; m_ovl = o;
      end else if (v) begin
        hist.push_back(int'(b));
        if (hist.size() > 8) void'(hist.pop_front());
        if (m_len != 0 && hist.size() >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (hist[hist.size() - 1 - k] != int'(m_pat[k])) hit = 0;
        end
        if (hit && !m_ovl) hist.delete();
      end
      exp_det = hit;
      if (clr) begin
        m_ca = 0; m_cb = 0;
      end else if (hit) begin
        m_ca = (m_ca < 65535) ? m_ca + 1 : m_ca;
        m_cb = (m_cb < 3) ? m_cb + 1 : m_cb;
      end
    end
    @(posedge clock);
    #1;
    chk("det", 32'(det_a), 32'(exp_det));
    chk("det_s", 32'(det_b), 32'(exp_det));
    chk("count", 32'(cnt_a), 32'(ce(m_ca)));
    chk("count_s", 32'(cnt_b), 32'(ce(m_cb)));
    chk("cur_len", 32'(len_a), 32'(m_len));
    chk("cur_len_s", 32'(len_b), 32'(m_len));
  endtask

  task automatic sb(bit b); cyc(b, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic gap(); cyc(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic clr(); cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic rst(); cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic load(logic [7:0] p, int l, bit o); cyc(1, 1, 1, 0, 0, p, l, o); endtask
  task automatic stream(logic [15:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) sb(bits[i]);
  endtask

  initial begin
    rst(); rst();
    stream(16'b010010, 6);
    chk("t1_count", 32'(cnt_a), 32'(ce(1)));
    clr();
    stream(16'b1001001, 7);
    chk("t2_overlap_count", 32'(cnt_a), 32'(ce(2)));
    clr();
    load(8'b1001, 4, 0);
    stream(16'b1001001, 7);
    chk("t2_nonoverlap_count", 32'(cnt_a), 32'(ce(1)));
    clr();
    rst();
    stream(16'b100, 3);
    load(8'b110, 3, 1);
    stream(16'b110110, 6);
    chk("t3_reprogram_count", 32'(cnt_a), 32'(ce(2)));
    rst();
    for (int i = 3; i >= 0; i--) begin
      sb(i == 2 || i == 1 ? 1'b0 : 1'b1);
      if (i != 0) begin gap(); gap(); gap(); end
    end
    gap();
    chk("t4_gap_count", 32'(cnt_a), 32'(ce(1)));
    clr();
    sb(1);
    for (int i = 0; i < 5; i++) stream(16'b001, 3);
    chk("t5_sat_count", 32'(cnt_b), 32'(ce(3)));
    sb(0); sb(0);
    cyc(1, 1, 0, 1, 0, 0, 0, 0);
    chk("t5_clr_wins", 32'(cnt_b), 32'd0);
    stream(16'b100, 3);
    rst();
    sb(1);
    chk("t6_reset_lost", 32'(det_a), 32'd0);
    load(8'h00, 0, 1);
    for (int i = 0; i < 20; i++) sb(1'($urandom));
    load(8'hA5, 11, 1);
    chk("t6_clamp", 32'(len_a), 32'd8);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r == 0) rst();
      else if (r < 5) load(8'($urandom), int'($urandom_range(0, 11)), 1'($urandom));
      else if (r < 10) cyc(1'($urandom), 1'($urandom), 0, 1, 0, 0, 0, 0);
      else if (r < 50) gap();
      else sb(1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
